dmem_arbiter: RTL and testbench

Two-port arbiter for the processor's single-port data memory (256 x 16, synchronous read, one-cycle latency). It shares the memory between the CPU datapath port, driven by the control FSM's D_Addr/D_Wr path, and an external loader port used to preload or inspect data memory. It sequences every access through an explicit state machine and returns read data with a one-cycle valid pulse. The FSM treats a missing Cpu_Gnt as a stall.

---
 rtl/dmem_arb_pkg.sv | 18 +
 rtl/dmem_arbiter_rr_pick2.sv | 23 ++
 rtl/dmem_arbiter.sv | 106 ++++++++++
 tb/tb_dmem_arbiter.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and widths for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_LD  = 1'b1
  } req_id_t;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-requester picker: round-robin against Last, or CPU-first
// when prio_en is set.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic    cpu_req,
  input  logic    ld_req,
  input  req_id_t last,
  input  logic    prio_en,
  output req_id_t winner,
  output logic    found
);

  always_comb begin
    found  = cpu_req | ld_req;
    winner = REQ_CPU;
    if (cpu_req && ld_req)
      winner = (prio_en || last == REQ_LD) ? REQ_CPU : REQ_LD;
    else if (ld_req)
      winner = REQ_LD;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port sync-read data memory between the CPU and a loader port.
// Define DMEM_ARB_CPU_PRIO_EN for fixed CPU priority; default is round-robin.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DMEM_ADDR_W,
  parameter int DATA_W = DMEM_DATA_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Cpu_Req,
  input  logic              Cpu_Wr,
  input  logic [ADDR_W-1:0] Cpu_Addr,
  input  logic [DATA_W-1:0] Cpu_WData,
  output logic              Cpu_Gnt,
  output logic              Cpu_Valid,
  output logic [DATA_W-1:0] Cpu_RData,
  input  logic              Ld_Req,
  input  logic              Ld_Wr,
  input  logic [ADDR_W-1:0] Ld_Addr,
  input  logic [DATA_W-1:0] Ld_WData,
  output logic              Ld_Gnt,
  output logic              Ld_Valid,
  output logic [DATA_W-1:0] Ld_RData,
  output logic [ADDR_W-1:0] M_Addr,
  output logic              M_Wr,
  output logic [DATA_W-1:0] M_WData,
  input  logic [DATA_W-1:0] M_RData,
  output logic              Busy
);

`ifdef DMEM_ARB_CPU_PRIO_EN
  localparam logic PRIO_EN = 1'b1;
`else
  localparam logic PRIO_EN = 1'b0;
`endif

  state_t            state, state_nxt;
  req_id_t           last, win, lat_id;
  logic              found;
  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  rr_pick2 u_pick (
    .cpu_req (Cpu_Req),
    .ld_req  (Ld_Req),
    .last    (last),
    .prio_en (PRIO_EN),
    .winner  (win),
    .found   (found)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= IDLE;
      last      <= REQ_LD;
      lat_id    <= REQ_CPU;
      lat_wr    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else begin
      state <= state_nxt;
      // Requests are only sampled here; the latch holds the access until done.
      if (state == IDLE && found) begin
        last      <= win;
        lat_id    <= win;
        lat_wr    <= (win == REQ_CPU) ? Cpu_Wr    : Ld_Wr;
        lat_addr  <= (win == REQ_CPU) ? Cpu_Addr  : Ld_Addr;
        lat_wdata <= (win == REQ_CPU) ? Cpu_WData : Ld_WData;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    Cpu_Gnt   = 1'b0;
    Ld_Gnt    = 1'b0;
    Cpu_Valid = 1'b0;
    Ld_Valid  = 1'b0;
    Cpu_RData = '0;
    Ld_RData  = '0;
    M_Wr      = 1'b0;
    M_Addr    = lat_addr;
    M_WData   = lat_wdata;
    Busy      = (state != IDLE);
    case (state)
      IDLE: if (found) state_nxt = ACCESS;
      ACCESS: begin
        M_Wr      = lat_wr;
        Cpu_Gnt   = (lat_id == REQ_CPU);
        Ld_Gnt    = (lat_id == REQ_LD);
        state_nxt = lat_wr ? IDLE : RDATA;
      end
      RDATA: begin
        Cpu_Valid = (lat_id == REQ_CPU);
        Ld_Valid  = (lat_id == REQ_LD);
        if (lat_id == REQ_CPU) Cpu_RData = M_RData;
        else                   Ld_RData  = M_RData;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed + randomized bench for dmem_arbiter against a transaction-level model.
module tb_dmem_arbiter;

  logic        Clk = 1'b0, Rst = 1'b1;
  logic        Cpu_Req = 0, Cpu_Wr = 0, Ld_Req = 0, Ld_Wr = 0;
  logic [7:0]  Cpu_Addr = 0, Ld_Addr = 0, M_Addr;
  logic [15:0] Cpu_WData = 0, Ld_WData = 0, M_WData, M_RData, Cpu_RData, Ld_RData;
  logic        Cpu_Gnt, Cpu_Valid, Ld_Gnt, Ld_Valid, M_Wr, Busy;

  dmem_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .Cpu_Req(Cpu_Req), .Cpu_Wr(Cpu_Wr), .Cpu_Addr(Cpu_Addr), .Cpu_WData(Cpu_WData),
    .Cpu_Gnt(Cpu_Gnt), .Cpu_Valid(Cpu_Valid), .Cpu_RData(Cpu_RData),
    .Ld_Req(Ld_Req), .Ld_Wr(Ld_Wr), .Ld_Addr(Ld_Addr), .Ld_WData(Ld_WData),
    .Ld_Gnt(Ld_Gnt), .Ld_Valid(Ld_Valid), .Ld_RData(Ld_RData),
    .M_Addr(M_Addr), .M_Wr(M_Wr), .M_WData(M_WData), .M_RData(M_RData), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  // The physical memory the arbiter drives.
  logic [15:0] tbmem [256];
  always @(posedge Clk) begin
    if (M_Wr) tbmem[M_Addr] <= M_WData;
    M_RData <= tbmem[M_Addr];
  end

  // Reference model: expected memory contents, pending request per port, Last.
  logic [15:0] refmem [256];
  bit          p_pend [2];
  bit          p_wr   [2];
  logic [7:0]  p_addr [2];
  logic [15:0] p_wd   [2];
  int          m_last;
  int          last_w;
  int          n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk); #1;
  endtask

  task automatic drive();
    Cpu_Req = p_pend[0]; Cpu_Wr = p_wr[0]; Cpu_Addr = p_addr[0]; Cpu_WData = p_wd[0];
    Ld_Req  = p_pend[1]; Ld_Wr  = p_wr[1]; Ld_Addr  = p_addr[1]; Ld_WData  = p_wd[1];
  endtask

  task automatic set_req(input int p, input bit wr, input logic [7:0] a, input logic [15:0] d);
    p_pend[p] = 1; p_wr[p] = wr; p_addr[p] = a; p_wd[p] = d;
  endtask

  function automatic int pick();
    if (p_pend[0] && p_pend[1]) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
      return 0;
`else
      return (m_last == 0) ? 1 : 0;
`endif
    end
    return p_pend[0] ? 0 : 1;
  endfunction

  task automatic do_reset();
    Rst = 1; p_pend[0] = 0; p_pend[1] = 0; drive();
    step(); step();
    Rst = 0; m_last = 1;
  endtask

  // One complete access from the IDLE sampling cycle back to IDLE.
  task automatic run_round();
    int w;
    drive();
    chk("idle_busy", Busy, 0);
    chk("idle_gnt", {Cpu_Gnt, Ld_Gnt}, 0);
    w = pick();
    step();
    chk("acc_busy", Busy, 1);
    chk("cpu_gnt", Cpu_Gnt, (w == 0));
    chk("ld_gnt", Ld_Gnt, (w == 1));
    chk("m_wr", M_Wr, p_wr[w]);
    chk("m_addr", M_Addr, p_addr[w]);
    if (p_wr[w]) begin
      chk("m_wdata", M_WData, p_wd[w]);
      refmem[p_addr[w]] = p_wd[w];
    end
    m_last = w; last_w = w;
    p_pend[w] = 0; drive();
    if (!p_wr[w]) begin
      step();
      chk("rd_busy", Busy, 1);
      chk("rd_mwr", M_Wr, 0);
      chk("cpu_valid", Cpu_Valid, (w == 0));
      chk("ld_valid", Ld_Valid, (w == 1));
      chk("cpu_rdata", Cpu_RData, (w == 0) ? refmem[p_addr[w]] : 16'h0);
      chk("ld_rdata", Ld_RData, (w == 1) ? refmem[p_addr[w]] : 16'h0);
    end
    step();
    chk("end_busy", Busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbmem[i]  = 16'(i * 7) ^ 16'h5A5A;
      refmem[i] = 16'(i * 7) ^ 16'h5A5A;
    end
    tbmem[8'h10] = 16'h1234; refmem[8'h10] = 16'h1234;
    p_pend[0] = 0; p_pend[1] = 0; m_last = 1;

    // Outputs during reset
    step(); step();
    chk("rst_outs", {Cpu_Gnt, Cpu_Valid, Ld_Gnt, Ld_Valid, M_Wr, Busy}, 0);
    chk("rst_rdata", {Cpu_RData, Ld_RData}, 0);
    chk("rst_maddr", M_Addr, 0);
    chk("rst_mwdata", M_WData, 0);
    Rst = 0;

    // CPU read, write, read back
    set_req(0, 0, 8'h10, 16'h0); run_round();
    set_req(0, 1, 8'h20, 16'hABCD); run_round();
    set_req(0, 0, 8'h20, 16'h0); run_round();

    // Both ports contending with writes
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!p_pend[0]) set_req(0, 1, 8'(8'h40 + i), 16'(16'hC000 + i));
      if (!p_pend[1]) set_req(1, 1, 8'(8'h80 + i), 16'(16'hD000 + i));
      run_round();
`ifdef DMEM_ARB_CPU_PRIO_EN
      chk("order", last_w, 0);
`else
      chk("order", last_w, i % 2);
`endif
    end
    while (p_pend[0] || p_pend[1]) run_round();

    // Loader write then immediate CPU read
    set_req(1, 1, 8'h05, 16'h00FF); run_round();
    set_req(0, 0, 8'h05, 16'h0); run_round();
    chk("ld_to_cpu", refmem[8'h05], 16'h00FF);

    // Reset during RDATA of a loader read
    set_req(1, 0, 8'h33, 16'h0); drive();
    step();
    chk("mr_ldgnt", Ld_Gnt, 1);
    p_pend[1] = 0; drive();
    step();
    chk("mr_ldvalid_pre", Ld_Valid, 1);
    Rst = 1; #1;
    chk("mr_ldvalid", Ld_Valid, 0);
    chk("mr_ldrdata", Ld_RData, 0);
    chk("mr_busy", Busy, 0);
    chk("mr_maddr", M_Addr, 0);
    step(); Rst = 0; m_last = 1;
    set_req(0, 1, 8'h34, 16'h1111); set_req(1, 1, 8'h35, 16'h2222);
    run_round();
    chk("mr_first_cpu", last_w, 0);
    while (p_pend[0] || p_pend[1]) run_round();

    // Top address
    set_req(0, 1, 8'hFF, 16'hBEEF); run_round();
    set_req(0, 0, 8'hFF, 16'h0); run_round();

    // Randomized traffic
    for (int r = 0; r < 80; r++) begin
      for (int p = 0; p < 2; p++)
        if (!p_pend[p] && $urandom_range(0, 3) != 0)
          set_req(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7) * 37),
                  16'($urandom));
      if (!p_pend[0] && !p_pend[1]) begin
        drive(); step();
        chk("rand_idle", {Busy, Cpu_Gnt, Ld_Gnt}, 0);
      end else begin
        run_round();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
